// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch front end. The unit issues word fetches to instruction
//   memory and keeps a small prefetch buffer of {pc, instruction} pairs for
//   the decode stage. A branch redirect flushes the buffer. If a request is
//   still in flight when the redirect arrives, its data is discarded on ack.
//
// Parameters
//   DEPTH     prefetch buffer entries (power of two, 2..8)
//   RESET_PC  first fetch address after reset (word aligned)
//
// Ports
//   clock        single clock, rising edge
//   reset        asynchronous, active-high reset
//   mem_req      registered fetch request to instruction memory
//   mem_addr     registered word address of the current request
//   mem_ack      mem_rdata is valid for the pending request this cycle
//   mem_rdata    fetched instruction word
//   redirect     branch-taken pulse from execute
//   redirect_pc  branch target (bits [1:0] ignored)
//   inst_valid   head of the buffer holds an instruction
//   inst_out     instruction at the buffer head
//   inst_pc      address of inst_out
//   inst_ready   decode consumes the head entry
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] DEPTH_LAST = CW'(DEPTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;  // no request outstanding
    localparam logic [1:0] S_REQ  = 2'd1;  // request pending, data kept
    localparam logic [1:0] S_DROP = 2'd2;  // request pending, data discarded

    logic [1:0]    state, state_n;
    logic [31:0]   fetch_pc, fetch_pc_n;
    logic          mem_req_n;
    logic [31:0]   mem_addr_n;
    logic [AW-1:0] head, tail;
    logic [CW-1:0] count;
    logic [CW-1:0] occ_left;
    logic          push, pop;
    logic [31:0]   target_pc;

    logic [31:0] fifo_pc   [DEPTH];
    logic [31:0] fifo_data [DEPTH];

    assign target_pc  = redirect_pc & 32'hFFFF_FFFC;
    assign inst_valid = (count != '0);
    // A redirect flushes the buffer, so a pop in the same cycle is moot.
    assign pop        = inst_valid & inst_ready & ~redirect;
    // Occupancy after this edge's flush/pop, before any push.
    assign occ_left   = redirect ? '0 : (count - CW'(pop));

    assign inst_out = inst_valid ? fifo_data[head] : '0;
    assign inst_pc  = inst_valid ? fifo_pc[head]   : '0;

    always_comb begin
        // NOTE: every signal written here gets a default first so no latch
        // is inferred on paths that leave it untouched.
        state_n    = state;
        fetch_pc_n = fetch_pc;
        mem_req_n  = mem_req;
        mem_addr_n = mem_addr;
        push       = 1'b0;
        case (state)
            S_IDLE: begin
                if (redirect) fetch_pc_n = target_pc;
                // One slot must be free for the data of the new request.
                if (occ_left < DEPTH_FULL) begin
                    state_n    = S_REQ;
                    mem_req_n  = 1'b1;
                    mem_addr_n = fetch_pc_n;
                end
            end
            S_REQ: begin
                if (mem_ack) begin
                    if (redirect) begin
                        // Acked data belongs to the wrong path: drop it and
                        // go straight to the target.
                        fetch_pc_n = target_pc;
                        mem_addr_n = target_pc;
                    end else begin
                        push       = 1'b1;
                        fetch_pc_n = fetch_pc + 32'd4;
                        // After the push the buffer holds occ_left+1; keep
                        // requesting back-to-back while that leaves room.
                        if (occ_left < DEPTH_LAST) begin
                            mem_addr_n = fetch_pc_n;
                        end else begin
                            state_n   = S_IDLE;
                            mem_req_n = 1'b0;
                        end
                    end
                end else if (redirect) begin
                    // The request cannot be aborted; let it finish and
                    // throw its data away.
                    state_n    = S_DROP;
                    fetch_pc_n = target_pc;
                end
            end
            S_DROP: begin
                if (redirect) fetch_pc_n = target_pc;
                // The buffer is empty here, so reissue without a space check.
                if (mem_ack) begin
                    state_n    = S_REQ;
                    mem_addr_n = fetch_pc_n;
                end
            end
            default: begin
                state_n   = S_IDLE;
                mem_req_n = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            fetch_pc <= RESET_PC;
            mem_req  <= 1'b0;
            mem_addr <= RESET_PC;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            state    <= state_n;
            fetch_pc <= fetch_pc_n;
            mem_req  <= mem_req_n;
            mem_addr <= mem_addr_n;
            if (redirect) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) tail <= tail + AW'(1);
                if (pop)  head <= head + AW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // NOTE: the entry storage has no reset; an entry is only observed after
    // it has been written, and inst_out/inst_pc are forced to zero when empty.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_pc[tail]   <= fetch_pc;
            fifo_data[tail] <= mem_rdata;
        end
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the prefetch buffer entry count (power of two, 2..8).
REQ-002 Parameter RESET_PC, default 32'h0000_0000, SHALL set the first fetch address after reset.
REQ-003 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 mem_req  output  1  SHALL be the registered fetch request to instruction memory.
REQ-006 mem_addr  output  32  SHALL be the registered word address of the current request.
REQ-007 mem_ack  input  1  SHALL mark the cycle in which mem_rdata is valid for the pending request.
REQ-008 mem_rdata  input  32  SHALL carry the fetched instruction word.
REQ-009 redirect  input  1  SHALL be the branch-taken pulse from the execute datapath.
REQ-010 redirect_pc  input  32  SHALL be the branch target, valid while redirect=1.
REQ-011 inst_valid  output  1  SHALL indicate that inst_out/inst_pc hold a buffered instruction.
REQ-012 inst_out  output  32  SHALL be the instruction at the buffer head.
REQ-013 inst_pc  output  32  SHALL be the address of inst_out.
REQ-014 inst_ready  input  1  SHALL let the decode stage consume the head entry.

Function
REQ-015 FSM states SHALL be IDLE (no request), REQ (request pending), DROP (pending request to be discarded).
REQ-016 A request SHALL be issued only when occupancy plus outstanding requests is less than DEPTH; no overflow is possible.
REQ-017 Once mem_req=1, mem_req and mem_addr SHALL stay stable until the edge sampling mem_ack=1; no abort.
REQ-018 An ack in the same cycle mem_req first rises SHALL be accepted (zero-wait memory).
REQ-019 On ack in REQ: push {fetch_pc, mem_rdata}, fetch_pc += 4 (wraps modulo 2^32); if space remains, stay in REQ with mem_addr = new fetch_pc (no bubble), else go to IDLE.
REQ-020 IDLE SHALL move to REQ on the edge where space becomes available.
REQ-021 Pushed entry SHALL appear on inst_valid the cycle after the ack edge; steady state 1 instruction/cycle with zero-wait memory.
REQ-022 inst_valid SHALL equal (occupancy != 0); head pops on the edge where inst_valid & inst_ready.
REQ-023 Simultaneous push and pop SHALL keep occupancy unchanged; pop with full buffer frees the slot for a request on the same edge.
REQ-024 redirect SHALL flush all entries, set fetch_pc = redirect_pc, and override any pop in that cycle.
REQ-025 redirect in REQ without ack SHALL enter DROP; the old request stays asserted, its data is discarded on ack, then REQ at redirect_pc.
REQ-026 redirect with ack in the same cycle SHALL discard the acked data and issue redirect_pc on the next edge.
REQ-027 redirect in DROP SHALL update fetch_pc only; the state stays DROP.
REQ-028 redirect_pc bits [1:0] SHALL be forced to 0.

Reset
REQ-029 While reset=1: mem_req=0, mem_addr=RESET_PC, inst_valid=0, inst_out=0, inst_pc=0, occupancy=0, state IDLE.
REQ-030 Reset asserted mid-request SHALL drop the request immediately; any ack during reset is ignored.
REQ-031 First edge after reset release: mem_req=1, mem_addr=RESET_PC.

Verification
REQ-032 Zero-wait memory, inst_ready=1 -> inst_pc sequence 0,4,8,... on consecutive cycles, inst_out = memory contents.
REQ-033 inst_ready=0, DEPTH=4 -> exactly 4 acks accepted, mem_req low, inst_pc=0; one pop -> one new request to addr 16.
REQ-034 3-cycle ack latency, redirect to 0x40 one cycle after request to 0x8 -> 0x8 data discarded; next valid inst_pc=0x40.
REQ-035 redirect to 0x100 with mem_ack=1 and inst_ready=1 in the same cycle -> buffer empty next cycle; next mem_addr=0x100.
REQ-036 fetch_pc=0xFFFF_FFFC ack -> next mem_addr=0x0000_0000.
REQ-037 reset pulse with 3 entries buffered and request pending -> inst_valid=0, mem_req=0 immediately; restart at RESET_PC.
